// File: rtl/uart_tx_engine_if.sv
// Handshake and line signals of the UART transmitter; the requester drives master, the engine is slave.
interface uart_tx_engine_if;
  logic       txStart;
  logic [7:0] TXData;
  logic       txOut;
  logic       CTS;
  logic       txDone;

  modport master (output txStart, output TXData, input txOut, input CTS, input txDone);
  modport slave  (input txStart, input TXData, output txOut, output CTS, output txDone);
endinterface

// File: rtl/uart_tx_engine.sv
// UART 8N1 transmitter; frame = 10*DIV cycles (11*DIV with UART_TX_PARITY_EN), line goes low the cycle after accept.
// Backpressure: txStart taken only while CTS=1; requests during a frame are dropped, never queued.
module uart_tx_engine #(
  parameter int SYSCLK = 10000000,
  parameter int BAUD   = 115200
) (
  input logic             CLK,
  input logic             RST,
  uart_tx_engine_if.slave bus
);

  localparam int DIV = SYSCLK / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          tx_q, tx_d;
  logic          wrap;

  assign wrap = (cnt == CNT_MAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = wrap ? '0 : cnt + 1'b1;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    tx_d      = tx_q;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (bus.txStart) begin
          shreg_d = bus.TXData;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (wrap) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shreg[0];
        end
      end
      DATA: begin
        if (wrap) begin
          if (bit_idx == 3'd7) begin
            bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            tx_d      = ^shreg;
`else
            state_d   = STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            tx_d      = shreg[bit_idx_d];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (wrap) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (wrap) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // txDone marks the final cycle of the stop bit, so it coincides with the last CTS=0 cycle.
  assign bus.txOut  = tx_q;
  assign bus.CTS    = (state == IDLE);
  assign bus.txDone = (state == STOP) && wrap;

endmodule
